de2_70_nios_oci_dct_packer: RTL and testbench

- Upstream stage of the OCI trace test-bench monitor.
- Collects 2-bit direct-control-transfer (DCT) codes from the CPU trace logic and packs up to 15 of them into a 30-bit frame (dct_buffer) with a fill count (dct_count).
- Hands each frame downstream over a valid/ready handshake.
- Sequences end of test (test_ending, test_has_ended) after a stop request drains the trace.

---
 rtl/de2_70_nios_oci_dct_packer.sv | 173 +++++++++++++++++
 tb/tb_de2_70_nios_oci_dct_packer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/de2_70_nios_oci_dct_packer.sv
// Packs 2-bit DCT trace codes into 15-slot frames, hands them off over valid/ready, and sequences end of test.
// Optional DCT_DROP_COUNT_EN adds a saturating dropped-code counter output.
module de2_70_nios_oci_dct_packer #(
    parameter int unsigned CODE_W  = 2,
    parameter int unsigned DEPTH   = 15,
    parameter int unsigned COUNT_W = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      dct_valid,
    input  logic [CODE_W-1:0]         dct_code,
    input  logic                      flush,
    input  logic                      trace_stop,
    output logic [CODE_W*DEPTH-1:0]   dct_buffer,
    output logic [COUNT_W-1:0]        dct_count,
    output logic                      dct_out_valid,
    input  logic                      dct_out_ready,
    output logic                      overflow,
    output logic                      test_ending,
    output logic                      test_has_ended
`ifdef DCT_DROP_COUNT_EN
    ,output logic [7:0]               dct_drop_count
`endif
);

    localparam int unsigned BUF_W = CODE_W * DEPTH;
    localparam logic [COUNT_W-1:0] FULL_CNT = COUNT_W'(DEPTH);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_ENDING = 2'd2;
    localparam logic [1:0] ST_ENDED  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [BUF_W-1:0]   acc_q, acc_d;
    logic [COUNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic [BUF_W-1:0]   frame_q, frame_d;
    logic [COUNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               out_valid_q, out_valid_d;
    logic               overflow_q, overflow_d;
    logic               test_ending_q, test_ending_d;
    logic               test_has_ended_q, test_has_ended_d;

    logic               out_free;
    logic               acc_full;
    logic               code_en;
    logic               drop;
    logic               flush_en;
    logic               transfer;
    logic [BUF_W-1:0]   merged;
    logic [COUNT_W-1:0] merged_cnt;

    // Accumulator, frame register and handshake
    always_comb begin
        out_free    = !out_valid_q || dct_out_ready;
        acc_full    = (acc_cnt_q == FULL_CNT);
        code_en     = (state_q == ST_RUN) && dct_valid;
        drop        = code_en && acc_full && !out_free;
        flush_en    = ((state_q == ST_RUN) && flush) || (state_q == ST_DRAIN);
        merged      = acc_q;
        merged_cnt  = acc_cnt_q;
        transfer    = 1'b0;
        acc_d       = acc_q;
        acc_cnt_d   = acc_cnt_q;
        frame_d     = frame_q;
        frame_cnt_d = frame_cnt_q;

        if (acc_full) begin
            // A full accumulator moves out first; a same-edge code starts the next frame.
            if (out_free) begin
                transfer    = 1'b1;
                frame_d     = acc_q;
                frame_cnt_d = acc_cnt_q;
                acc_d       = code_en ? BUF_W'(dct_code) : '0;
                acc_cnt_d   = code_en ? COUNT_W'(1) : '0;
            end
        end else begin
            if (code_en) begin
                merged     = acc_q | (BUF_W'(dct_code) << (CODE_W * acc_cnt_q));
                merged_cnt = acc_cnt_q + COUNT_W'(1);
            end
            if (out_free && ((merged_cnt == FULL_CNT) ||
                             (flush_en && (merged_cnt != '0)))) begin
                transfer    = 1'b1;
                frame_d     = merged;
                frame_cnt_d = merged_cnt;
                acc_d       = '0;
                acc_cnt_d   = '0;
            end else begin
                acc_d     = merged;
                acc_cnt_d = merged_cnt;
            end
        end

        if (transfer) begin
            out_valid_d = 1'b1;
        end else if (out_valid_q && dct_out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        overflow_d = overflow_q | drop;
    end

    // End-of-test sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (trace_stop) state_d = ST_DRAIN;
            ST_DRAIN:  if ((acc_cnt_q == '0) && !out_valid_q) state_d = ST_ENDING;
            ST_ENDING: state_d = ST_ENDED;
            ST_ENDED:  state_d = ST_ENDED;
            default:   state_d = ST_RUN;
        endcase
        test_ending_d    = (state_d == ST_ENDING);
        test_has_ended_d = test_has_ended_q || (state_d == ST_ENDED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_RUN;
            acc_q            <= '0;
            acc_cnt_q        <= '0;
            frame_q          <= '0;
            frame_cnt_q      <= '0;
            out_valid_q      <= 1'b0;
            overflow_q       <= 1'b0;
            test_ending_q    <= 1'b0;
            test_has_ended_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            acc_q            <= acc_d;
            acc_cnt_q        <= acc_cnt_d;
            frame_q          <= frame_d;
            frame_cnt_q      <= frame_cnt_d;
            out_valid_q      <= out_valid_d;
            overflow_q       <= overflow_d;
            test_ending_q    <= test_ending_d;
            test_has_ended_q <= test_has_ended_d;
        end
    end

`ifdef DCT_DROP_COUNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of codes lost to backpressure
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign dct_drop_count = drop_cnt_q;
`endif

    assign dct_buffer     = frame_q;
    assign dct_count      = frame_cnt_q;
    assign dct_out_valid  = out_valid_q;
    assign overflow       = overflow_q;
    assign test_ending    = test_ending_q;
    assign test_has_ended = test_has_ended_q;

endmodule

// File: tb/tb_de2_70_nios_oci_dct_packer.sv
// Directed bench for the DCT packer; expected frames are queued by a packing model and compared on handshake.
module tb_de2_70_nios_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        dct_valid;
    logic [1:0]  dct_code;
    logic        flush;
    logic        trace_stop;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        dct_out_valid;
    logic        dct_out_ready;
    logic        overflow;
    logic        test_ending;
    logic        test_has_ended;
`ifdef DCT_DROP_COUNT_EN
    logic [7:0]  dct_drop_count;
`endif

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [33:0] exp_q[$];
    logic [29:0] m_acc;
    int          m_cnt;

    de2_70_nios_oci_dct_packer dut (
        .clk            (clk),
        .reset          (reset),
        .dct_valid      (dct_valid),
        .dct_code       (dct_code),
        .flush          (flush),
        .trace_stop     (trace_stop),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .dct_out_valid  (dct_out_valid),
        .dct_out_ready  (dct_out_ready),
        .overflow       (overflow),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended)
`ifdef DCT_DROP_COUNT_EN
        ,.dct_drop_count(dct_drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_add(input logic [1:0] c);
        m_acc = m_acc | (30'(c) << (2 * m_cnt));
        m_cnt++;
        if (m_cnt == 15) begin
            exp_q.push_back({4'(m_cnt), m_acc});
            m_acc = '0;
            m_cnt = 0;
        end
    endtask

    task automatic model_flush();
        if (m_cnt > 0) begin
            exp_q.push_back({4'(m_cnt), m_acc});
            m_acc = '0;
            m_cnt = 0;
        end
    endtask

    // keep: when 1 the code is expected to be packed, when 0 it is expected to be dropped/ignored
    task automatic send(input logic [1:0] c, input bit keep);
        dct_valid = 1'b1;
        dct_code  = c;
        tick();
        dct_valid = 1'b0;
        if (keep) model_add(c);
    endtask

    // Scoreboard: every accepted frame must match the oldest expected frame
    always @(negedge clk) begin
        logic [33:0] e;
        if (!reset && dct_out_valid && dct_out_ready) begin
            chk("frame_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("frame_count", 32'(dct_count), 32'(e[33:30]));
                chk("frame_buffer", 32'(dct_buffer), 32'(e[29:0]));
            end
        end
    end

    initial begin
        m_acc = '0;
        m_cnt = 0;
        reset = 1'b1;
        dct_valid = 1'b0;
        dct_code = 2'd0;
        flush = 1'b0;
        trace_stop = 1'b0;
        dct_out_ready = 1'b1;
        tick();
        tick();
        chk("rst_buffer", 32'(dct_buffer), 32'd0);
        chk("rst_count", 32'(dct_count), 32'd0);
        chk("rst_valid", 32'(dct_out_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_ending", 32'(test_ending), 32'd0);
        chk("rst_ended", 32'(test_has_ended), 32'd0);
        reset = 1'b0;
        tick();

        // Full frame of codes 1,2,3 repeating with ready held high
        for (int i = 0; i < 15; i++) send(2'((i % 3) + 1), 1'b1);
        chk("full_valid", 32'(dct_out_valid), 32'd1);
        chk("full_count", 32'(dct_count), 32'd15);
        chk("full_buffer", 32'(dct_buffer), 32'h39E79E79);
        chk("full_overflow", 32'(overflow), 32'd0);
        tick();
        chk("full_valid_1cyc", 32'(dct_out_valid), 32'd0);

        // Partial frame by flush
        send(2'd3, 1'b1);
        send(2'd1, 1'b1);
        send(2'd2, 1'b1);
        chk("pre_flush_valid", 32'(dct_out_valid), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        model_flush();
        chk("flush_valid", 32'(dct_out_valid), 32'd1);
        chk("flush_count", 32'(dct_count), 32'd3);
        chk("flush_buffer", 32'(dct_buffer), 32'h27);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("empty_flush_noop", 32'(dct_out_valid), 32'd0);

        // Full accumulator behind a stalled frame; ready and a new code on the same edge
        dct_out_ready = 1'b0;
        for (int i = 0; i < 30; i++) send(2'($urandom_range(0, 3)), 1'b1);
        chk("stall_valid", 32'(dct_out_valid), 32'd1);
        chk("stall_overflow", 32'(overflow), 32'd0);
        dct_out_ready = 1'b1;
        send(2'd2, 1'b1);
        chk("sameedge_valid", 32'(dct_out_valid), 32'd1);
        chk("sameedge_count", 32'(dct_count), 32'd15);
        chk("sameedge_overflow", 32'(overflow), 32'd0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        model_flush();
        chk("slot0_count", 32'(dct_count), 32'd1);
        chk("slot0_buffer", 32'(dct_buffer), 32'd2);
        tick();

        // Backpressure: 32 codes with ready low, the last two are dropped
        dct_out_ready = 1'b0;
        for (int i = 0; i < 32; i++) send(2'($urandom_range(0, 3)), (i < 30) ? 1'b1 : 1'b0);
        chk("bp_overflow", 32'(overflow), 32'd1);
        chk("bp_valid", 32'(dct_out_valid), 32'd1);
        chk("bp_count", 32'(dct_count), 32'd15);
`ifdef DCT_DROP_COUNT_EN
        chk("bp_drop_count", 32'(dct_drop_count), 32'd2);
`endif
        dct_out_ready = 1'b1;
        tick();
        chk("bp_second_valid", 32'(dct_out_valid), 32'd1);
        tick();
        chk("bp_drained", 32'(dct_out_valid), 32'd0);
        chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of a partial frame
        for (int i = 0; i < 7; i++) send(2'($urandom_range(0, 3)), 1'b1);
        #2;
        reset = 1'b1;
        m_acc = '0;
        m_cnt = 0;
        #1;
        chk("arst_overflow", 32'(overflow), 32'd0);
        chk("arst_valid", 32'(dct_out_valid), 32'd0);
        chk("arst_buffer", 32'(dct_buffer), 32'd0);
        chk("arst_count", 32'(dct_count), 32'd0);
`ifdef DCT_DROP_COUNT_EN
        chk("arst_drop_count", 32'(dct_drop_count), 32'd0);
`endif
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 15; i++) send(2'($urandom_range(0, 3)), 1'b1);
        chk("post_rst_valid", 32'(dct_out_valid), 32'd1);
        chk("post_rst_count", 32'(dct_count), 32'd15);
        tick();

        // Drain and end of test
        for (int i = 0; i < 5; i++) send(2'($urandom_range(0, 3)), 1'b1);
        trace_stop = 1'b1;
        tick();
        trace_stop = 1'b0;
        model_flush();
        tick();
        chk("drain_valid", 32'(dct_out_valid), 32'd1);
        chk("drain_count", 32'(dct_count), 32'd5);
        chk("drain_ending_early", 32'(test_ending), 32'd0);
        tick();
        chk("drain_accepted", 32'(dct_out_valid), 32'd0);
        chk("drain_ending_wait", 32'(test_ending), 32'd0);
        tick();
        chk("ending_pulse", 32'(test_ending), 32'd1);
        tick();
        chk("ending_one_cycle", 32'(test_ending), 32'd0);
        chk("has_ended", 32'(test_has_ended), 32'd1);
        for (int i = 0; i < 20; i++) send(2'($urandom_range(0, 3)), 1'b0);
        flush = 1'b1;
        trace_stop = 1'b1;
        tick();
        flush = 1'b0;
        trace_stop = 1'b0;
        tick();
        chk("ended_ignores_valid", 32'(dct_out_valid), 32'd0);
        chk("ended_no_overflow", 32'(overflow), 32'd0);
        chk("ended_sticky", 32'(test_has_ended), 32'd1);
        chk("ended_no_pulse", 32'(test_ending), 32'd0);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
